// File: rtl/rx_eyeq_seq_ctrl.sv
// RX eye-equalisation sequencer: walks the startup EQ phases for the latched link mode
// via a 4-way req/done handshake, then optionally loops background EQ.
module rx_eyeq_seq_ctrl #(
    parameter int unsigned EYEQMODE_W = 4,
    parameter int unsigned TIMEOUT_W  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  link_mode,
    input  logic                  bg_en,
    input  logic [1:0]            rxpdwn,
    input  logic [TIMEOUT_W-1:0]  timeout_cyc,
    input  logic                  rxeyeqdone,
    output logic                  rxeyeqreq,
    output logic [EYEQMODE_W-1:0] rxeyeqmode,
    output logic                  busy,
    output logic                  startup_done,
    output logic                  err_timeout,
    output logic                  err_proto
);

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StWaitLow,
        StGap,
        StAbort
    } state_e;

    // Phase index 2 denotes the background EQ mode.
    function automatic logic [EYEQMODE_W-1:0] phase_mode(input logic nrz, input logic [1:0] ph);
        logic [3:0] m;
        m = 4'h0;
        case (ph)
            2'd0:    m = nrz ? 4'b0100 : 4'b0001;
            2'd1:    m = nrz ? 4'b0101 : 4'b0010;
            default: m = nrz ? 4'b1100 : 4'b1010;
        endcase
        return EYEQMODE_W'(m);
    endfunction

    state_e                state_q, state_d;
    logic [EYEQMODE_W-1:0] mode_q, mode_d;
    logic [1:0]            phase_q, phase_d;
    logic [TIMEOUT_W-1:0]  cnt_q, cnt_d;
    logic                  link_q, link_d;
    logic                  done_prev_q;
    logic                  req_q, req_d;
    logic                  busy_q, busy_d;
    logic                  startup_done_q, startup_done_d;
    logic                  err_timeout_q, err_timeout_d;
    logic                  err_proto_q, err_proto_d;

    logic pdwn;
    logic done_rise;
    logic timeout_hit;

    assign pdwn        = (rxpdwn != 2'b00);
    assign done_rise   = rxeyeqdone & ~done_prev_q;
    // The entry cycle counts as cycle 1, so expiry lands exactly timeout_cyc cycles after entry.
    assign timeout_hit = (timeout_cyc != '0) && (cnt_q == timeout_cyc);

    always_comb begin
        state_d        = state_q;
        mode_d         = mode_q;
        phase_d        = phase_q;
        link_d         = link_q;
        startup_done_d = startup_done_q;
        err_timeout_d  = err_timeout_q;
        err_proto_d    = err_proto_q;
        cnt_d          = (cnt_q == '1) ? cnt_q : cnt_q + TIMEOUT_W'(1);

        unique case (state_q)
            StIdle: begin
                if (done_rise) begin
                    err_proto_d = 1'b1;
                end
                if (start && !pdwn) begin
                    link_d         = link_mode;
                    err_timeout_d  = 1'b0;
                    startup_done_d = 1'b0;
                    if (rxeyeqdone) begin
                        err_proto_d = 1'b1;
                        state_d     = StAbort;
                    end else begin
                        err_proto_d = 1'b0;
                        phase_d     = 2'd0;
                        mode_d      = phase_mode(link_mode, 2'd0);
                        state_d     = StReq;
                    end
                end
            end
            StReq, StWaitLow: begin
                if (pdwn) begin
                    startup_done_d = 1'b0;
                    state_d        = StAbort;
                end else if (timeout_hit) begin
                    err_timeout_d = 1'b1;
                    state_d       = StAbort;
                end else if (state_q == StReq && rxeyeqdone) begin
                    state_d = StWaitLow;
                end else if (state_q == StWaitLow && !rxeyeqdone) begin
                    state_d = StGap;
                end
            end
            StGap: begin
                if (pdwn) begin
                    startup_done_d = 1'b0;
                    state_d        = StAbort;
                end else begin
                    if (done_rise) begin
                        err_proto_d = 1'b1;
                    end
                    if (phase_q == 2'd1) begin
                        startup_done_d = 1'b1;
                    end
                    if (phase_q == 2'd0) begin
                        phase_d = 2'd1;
                        mode_d  = phase_mode(link_q, 2'd1);
                        state_d = StReq;
                    end else if (bg_en) begin
                        phase_d = 2'd2;
                        mode_d  = phase_mode(link_q, 2'd2);
                        state_d = StReq;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            StAbort: begin
                if (pdwn) begin
                    startup_done_d = 1'b0;
                end
                if (timeout_hit) begin
                    err_timeout_d = 1'b1;
                    state_d       = StIdle;
                end else if (!rxeyeqdone) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (state_d != state_q) begin
            cnt_d = TIMEOUT_W'(1);
        end

        req_d  = (state_d == StReq);
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= StIdle;
            mode_q         <= '0;
            phase_q        <= 2'd0;
            cnt_q          <= '0;
            link_q         <= 1'b0;
            done_prev_q    <= 1'b0;
            req_q          <= 1'b0;
            busy_q         <= 1'b0;
            startup_done_q <= 1'b0;
            err_timeout_q  <= 1'b0;
            err_proto_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            mode_q         <= mode_d;
            phase_q        <= phase_d;
            cnt_q          <= cnt_d;
            link_q         <= link_d;
            done_prev_q    <= rxeyeqdone;
            req_q          <= req_d;
            busy_q         <= busy_d;
            startup_done_q <= startup_done_d;
            err_timeout_q  <= err_timeout_d;
            err_proto_q    <= err_proto_d;
        end
    end

    assign rxeyeqreq    = req_q;
    assign rxeyeqmode   = mode_q;
    assign busy         = busy_q;
    assign startup_done = startup_done_q;
    assign err_timeout  = err_timeout_q;
    assign err_proto    = err_proto_q;

endmodule

// File: tb/tb_rx_eyeq_seq_ctrl.sv
// Bench for rx_eyeq_seq_ctrl: an EQ-engine responder with random delays, checked against
// the phase tables and cycle-level handshake timing.
module tb_rx_eyeq_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        link_mode = 1'b0;
    logic        bg_en = 1'b0;
    logic [1:0]  rxpdwn = 2'b00;
    logic [15:0] timeout_cyc = 16'd0;
    logic        rxeyeqdone = 1'b0;
    logic        rxeyeqreq;
    logic [3:0]  rxeyeqmode;
    logic        busy;
    logic        startup_done;
    logic        err_timeout;
    logic        err_proto;

    int n_chk = 0;
    int n_err = 0;

    rx_eyeq_seq_ctrl #(
        .EYEQMODE_W(4),
        .TIMEOUT_W (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .link_mode   (link_mode),
        .bg_en       (bg_en),
        .rxpdwn      (rxpdwn),
        .timeout_cyc (timeout_cyc),
        .rxeyeqdone  (rxeyeqdone),
        .rxeyeqreq   (rxeyeqreq),
        .rxeyeqmode  (rxeyeqmode),
        .busy        (busy),
        .startup_done(startup_done),
        .err_timeout (err_timeout),
        .err_proto   (err_proto)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Handshake index 0,1 are startup phases; 2 and above are background EQ.
    function automatic logic [3:0] exp_mode(input logic nrz, input int idx);
        logic [3:0] tbl [0:2];
        if (nrz) begin
            tbl[0] = 4'b0100; tbl[1] = 4'b0101; tbl[2] = 4'b1100;
        end else begin
            tbl[0] = 4'b0001; tbl[1] = 4'b0010; tbl[2] = 4'b1010;
        end
        return tbl[(idx > 2) ? 2 : idx];
    endfunction

    task automatic run_seq(input logic lm, input int bg_reps);
        int n;
        int d;
        int f;
        logic [3:0] em;
        n = 2 + bg_reps;
        em = 4'h0;
        chk("idle_before", busy, 0);
        bg_en = (bg_reps > 0);
        link_mode = lm;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (i > 0) begin
                step();
                step();
            end
            em = exp_mode(lm, i);
            chk("req_rise", rxeyeqreq, 1);
            chk("mode", rxeyeqmode, em);
            chk("startup_done_in_seq", startup_done, (i >= 2));
            chk("err_timeout_in_seq", err_timeout, 0);
            chk("err_proto_in_seq", err_proto, 0);
            if (i == n - 1) bg_en = 1'b0;
            d = $urandom_range(1, 8);
            repeat (d) step();
            chk("req_hold", rxeyeqreq, 1);
            chk("mode_req", rxeyeqmode, em);
            rxeyeqdone = 1'b1;
            step();
            chk("req_fall", rxeyeqreq, 0);
            f = $urandom_range(1, 4);
            repeat (f - 1) step();
            chk("mode_waitlow", rxeyeqmode, em);
            rxeyeqdone = 1'b0;
        end
        step();
        chk("gap_busy", busy, 1);
        step();
        chk("end_busy", busy, 0);
        chk("end_req", rxeyeqreq, 0);
        chk("end_startup_done", startup_done, 1);
        chk("end_mode_held", rxeyeqmode, em);
        chk("end_err_proto", err_proto, 0);
    endtask

    initial begin
        step();
        step();
        chk("rst_req", rxeyeqreq, 0);
        chk("rst_mode", rxeyeqmode, 0);
        chk("rst_busy", busy, 0);
        chk("rst_startup_done", startup_done, 0);
        chk("rst_err_timeout", err_timeout, 0);
        chk("rst_err_proto", err_proto, 0);
        rst = 1'b0;
        step();

        // NRZ normal, ENRZ with three background loops
        run_seq(1'b1, 0);
        run_seq(1'b0, 3);

        // Timeout with done stuck low
        timeout_cyc = 16'd20;
        link_mode = 1'b0;
        bg_en = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("to_req", rxeyeqreq, 1);
        repeat (19) step();
        chk("to_early", err_timeout, 0);
        chk("to_req_early", rxeyeqreq, 1);
        step();
        chk("to_fire", err_timeout, 1);
        chk("to_req_drop", rxeyeqreq, 0);
        step();
        chk("to_idle", busy, 0);
        run_seq(1'b1, 1);

        // Randomized runs
        for (int r = 0; r < 4; r++) begin
            run_seq(1'($urandom_range(0, 1)), $urandom_range(0, 3));
        end

        // Powerdown during phase 2 REQ with done high
        link_mode = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        rxeyeqdone = 1'b1;
        step();
        rxeyeqdone = 1'b0;
        step();
        step();
        chk("pd_req2", rxeyeqreq, 1);
        chk("pd_mode2", rxeyeqmode, 4'b0101);
        rxeyeqdone = 1'b1;
        rxpdwn = 2'b01;
        step();
        chk("pd_req_drop", rxeyeqreq, 0);
        chk("pd_busy", busy, 1);
        chk("pd_startup_done", startup_done, 0);
        repeat (3) step();
        chk("pd_abort_hold", busy, 1);
        rxeyeqdone = 1'b0;
        step();
        chk("pd_idle", busy, 0);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("pd_start_ignored", busy, 0);
        rxpdwn = 2'b00;
        step();

        // Done already high at start
        rxeyeqdone = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("pr_start_err", err_proto, 1);
        chk("pr_start_req", rxeyeqreq, 0);
        chk("pr_start_busy", busy, 1);
        rxeyeqdone = 1'b0;
        step();
        chk("pr_start_idle", busy, 0);
        chk("pr_start_req2", rxeyeqreq, 0);
        run_seq(1'b0, 0);

        // Spurious done pulse during GAP
        link_mode = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        rxeyeqdone = 1'b1;
        step();
        rxeyeqdone = 1'b0;
        step();
        chk("gap_req_low", rxeyeqreq, 0);
        chk("gap_busy_hi", busy, 1);
        rxeyeqdone = 1'b1;
        step();
        rxeyeqdone = 1'b0;
        chk("gap_err_proto", err_proto, 1);
        chk("gap_next_req", rxeyeqreq, 1);
        chk("gap_next_mode", rxeyeqmode, 4'b0101);
        step();
        rxeyeqdone = 1'b1;
        step();
        rxeyeqdone = 1'b0;
        step();
        step();
        chk("gap_end_idle", busy, 0);
        chk("gap_err_sticky", err_proto, 1);

        // Reset mid REQ
        link_mode = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        chk("mr_req", rxeyeqreq, 1);
        rst = 1'b1;
        #1;
        chk("mr_req_async", rxeyeqreq, 0);
        chk("mr_mode_async", rxeyeqmode, 0);
        chk("mr_busy_async", busy, 0);
        chk("mr_sd_async", startup_done, 0);
        chk("mr_errp_async", err_proto, 0);
        step();
        rst = 1'b0;
        step();
        run_seq(1'b1, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
